// File: rtl/shift_seq_pkg.sv
// Shared widths and the command record for the shift command sequencer.
// The record's tag uses the default tag width; the top builds its own record when TAG_W differs.
package shift_seq_pkg;

  localparam int DATA_W    = 32;
  localparam int AMT_W     = 5;
  localparam int TAG_W_DEF = 4;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [AMT_W-1:0]     amt;
    logic                 right;
    logic [TAG_W_DEF-1:0] tag;
  } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_sequencer_if.sv
// Command, shifter and result signals of the shift command sequencer.
// Signal names are seen from the sequencer side; slave is the sequencer, master the environment.
interface shift_cmd_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);

  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [DATA_W-1:0]      cmd_data_i;
  logic [AMT_W-1:0]       cmd_amt_i;
  logic                   cmd_right_i;
  logic [TAG_W-1:0]       cmd_tag_i;

  logic [DATA_W-1:0]      sh_data_o;
  logic [AMT_W-1:0]       sh_s_o;
  logic                   sh_right_o;
  logic [DATA_W-1:0]      sh_y_i;

  logic                   res_valid_o;
  logic                   res_ready_i;
  logic [DATA_W-1:0]      res_data_o;
  logic [TAG_W-1:0]       res_tag_o;

  logic [$clog2(DEPTH):0] fifo_count_o;
  logic                   busy_o;

  modport slave (
    input  cmd_valid_i, cmd_data_i, cmd_amt_i, cmd_right_i, cmd_tag_i,
    input  sh_y_i, res_ready_i,
    output cmd_ready_o, sh_data_o, sh_s_o, sh_right_o,
    output res_valid_o, res_data_o, res_tag_o, fifo_count_o, busy_o
  );

  modport master (
    output cmd_valid_i, cmd_data_i, cmd_amt_i, cmd_right_i, cmd_tag_i,
    output sh_y_i, res_ready_i,
    input  cmd_ready_o, sh_data_o, sh_s_o, sh_right_o,
    input  res_valid_o, res_data_o, res_tag_o, fifo_count_o, busy_o
  );

endinterface

// File: rtl/shift_cmd_sequencer_fifo.sv
// Synchronous command FIFO; count is the sole full/empty indicator, pointers wrap naturally.
// Push while full and pop while empty are ignored, so a pop never frees a slot in the same cycle.
module shift_cmd_fifo
  import shift_seq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = shift_cmd_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       data_i,
  output T                       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Buffered front-end for a combinational barrel shifter: FIFO -> issue register -> result register.
// The shifter sits between the issue and result registers, outside this block.
module shift_cmd_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  shift_cmd_sequencer_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              right;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  cmd_t                   w_cmd_p0;
  cmd_t                   w_head_p0;
  logic [$clog2(DEPTH):0] w_count_p0;
  logic                   w_full_p0;
  logic                   w_empty_p0;
  logic                   w_pop_p0;
  logic                   w_res_adv_p1;

  cmd_t                   r_iss_p1;
  logic                   r_vld_p1;
  logic [DATA_W-1:0]      r_data_p2;
  logic [TAG_W-1:0]       r_tag_p2;
  logic                   r_vld_p2;

  assign w_cmd_p0 = '{data:  bus.cmd_data_i,
                      amt:   bus.cmd_amt_i,
                      right: bus.cmd_right_i,
                      tag:   bus.cmd_tag_i};

  // Stage p0: command FIFO
  shift_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (bus.cmd_valid_i),
    .pop_i   (w_pop_p0),
    .data_i  (w_cmd_p0),
    .data_o  (w_head_p0),
    .count_o (w_count_p0),
    .full_o  (w_full_p0),
    .empty_o (w_empty_p0)
  );

  assign w_res_adv_p1 = r_vld_p1 && (!r_vld_p2 || bus.res_ready_i);
  assign w_pop_p0     = !w_empty_p0 && (!r_vld_p1 || w_res_adv_p1);

  // Stage p1: issue register, drives the shifter directly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_iss_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else if (w_pop_p0) begin
      r_iss_p1 <= w_head_p0;
      r_vld_p1 <= 1'b1;
    end else if (w_res_adv_p1) begin
      r_vld_p1 <= 1'b0;
    end
  end

  // Stage p2: result register captures the shifter output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data_p2 <= '0;
      r_tag_p2  <= '0;
      r_vld_p2  <= 1'b0;
    end else if (w_res_adv_p1) begin
      r_data_p2 <= bus.sh_y_i;
      r_tag_p2  <= r_iss_p1.tag;
      r_vld_p2  <= 1'b1;
    end else if (bus.res_ready_i && r_vld_p2) begin
      r_vld_p2  <= 1'b0;
    end
  end

  assign bus.cmd_ready_o  = !w_full_p0;
  assign bus.sh_data_o    = r_iss_p1.data;
  assign bus.sh_s_o       = r_iss_p1.amt;
  assign bus.sh_right_o   = r_iss_p1.right;
  assign bus.res_valid_o  = r_vld_p2;
  assign bus.res_data_o   = r_data_p2;
  assign bus.res_tag_o    = r_tag_p2;
  assign bus.fifo_count_o = w_count_p0;
  assign bus.busy_o       = !w_empty_p0 || r_vld_p1 || r_vld_p2;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Scoreboard bench for shift_cmd_sequencer with a behavioural logical shifter on the sh_* path.
module tb_shift_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_done = 0;

  logic [31:0]      exp_data_q [$];
  logic [TAG_W-1:0] exp_tag_q  [$];
  int               xfer_cyc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_cmd_sequencer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  shift_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Stand-in for barrel_shifter_multifunction: plain logical shift
  always_comb begin
    if (bus.sh_right_o) bus.sh_y_i = bus.sh_data_o >> bus.sh_s_o;
    else                bus.sh_y_i = bus.sh_data_o << bus.sh_s_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: a transfer happens at the next edge when valid && ready mid-cycle
  always @(negedge clk) begin
    #1;
    if (!rst && bus.res_valid_o && bus.res_ready_i) begin
      if (exp_data_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got data 0x%08h tag %0d, expected none", bus.res_data_o, bus.res_tag_o);
      end else begin
        check("res_data", bus.res_data_o, exp_data_q.pop_front());
        check("res_tag", 32'(bus.res_tag_o), 32'(exp_tag_q.pop_front()));
        xfer_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic r,
                      input logic [TAG_W-1:0] t, input logic [31:0] e);
    bit acc = 0;
    int tries = 0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_data_i  = d;
    bus.cmd_amt_i   = a;
    bus.cmd_right_i = r;
    bus.cmd_tag_i   = t;
    while (!acc) begin
      #1;
      acc = bus.cmd_ready_o;
      @(posedge clk);
      if (acc) begin
        exp_data_q.push_back(e);
        exp_tag_q.push_back(t);
      end else begin
        tries++;
        if (tries > 200) begin
          check("send_timeout", 32'(tries), 32'd0);
          break;
        end
        @(negedge clk);
      end
    end
    #1 bus.cmd_valid_i = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0]      d = $urandom;
    logic [4:0]       a = 5'($urandom_range(0, 31));
    logic             r = 1'($urandom_range(0, 1));
    logic [TAG_W-1:0] t = TAG_W'($urandom);
    logic [31:0]      e = r ? (d / (64'd1 << a)) : 32'(64'(d) * (64'd1 << a));
    send(d, a, r, t, e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_data_q.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check("drain_empty", 32'(exp_data_q.size()), 32'd0);
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_res_valid"}, 32'(bus.res_valid_o), 32'd0);
    check({pfx, "_res_data"}, bus.res_data_o, 32'd0);
    check({pfx, "_res_tag"}, 32'(bus.res_tag_o), 32'd0);
    check({pfx, "_sh_data"}, bus.sh_data_o, 32'd0);
    check({pfx, "_sh_s"}, 32'(bus.sh_s_o), 32'd0);
    check({pfx, "_sh_right"}, 32'(bus.sh_right_o), 32'd0);
    check({pfx, "_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
    check({pfx, "_count"}, 32'(bus.fifo_count_o), 32'd0);
    check({pfx, "_busy"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_data_i  = '0;
    bus.cmd_amt_i   = '0;
    bus.cmd_right_i = 1'b0;
    bus.cmd_tag_i   = '0;
    bus.res_ready_i = 1'b0;

    // Reset and hold
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_idle("reset");
    repeat (2) @(posedge clk);
    #1 check_idle("hold");

    // Single command latency
    bus.res_ready_i = 1'b1;
    send(32'hA5A5A5A5, 5'd4, 1'b1, 4'd3, 32'h0A5A5A5A);
    @(posedge clk);
    #1 check("lat_e1_valid", 32'(bus.res_valid_o), 32'd0);
    @(posedge clk);
    #1 check("lat_e2_valid", 32'(bus.res_valid_o), 32'd1);
    check("lat_e2_data", bus.res_data_o, 32'h0A5A5A5A);
    check("lat_e2_tag", 32'(bus.res_tag_o), 32'd3);
    wait_drain();

    // Back-to-back throughput and ordering
    xfer_cyc_q.delete();
    send(32'hA5A5A5A5, 5'd4, 1'b0, 4'd1, 32'h5A5A5A50);
    send(32'h12345678, 5'd5, 1'b0, 4'd2, 32'h468ACF00);
    send(32'h12345678, 5'd5, 1'b1, 4'd4, 32'h0091A2B3);
    send(32'hCAFEF00D, 5'd0, 1'b0, 4'd5, 32'hCAFEF00D);
    send(32'hCAFEF00D, 5'd0, 1'b1, 4'd6, 32'hCAFEF00D);
    send(32'hA5A5A5A5, 5'd31, 1'b1, 4'd7, 32'h00000001);
    send(32'hA5A5A5A5, 5'd31, 1'b0, 4'd8, 32'h80000000);
    wait_drain();
    check("b2b_count", 32'(xfer_cyc_q.size()), 32'd7);
    for (int i = 1; i < xfer_cyc_q.size(); i++)
      check("b2b_gap", 32'(xfer_cyc_q[i] - xfer_cyc_q[i-1]), 32'd1);

    // Back-pressure: DEPTH + 2 accepted, then full
    bus.res_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++)
      send(32'h0000_0100 << i, 5'(i), 1'b0, TAG_W'(i + 9), (32'h0000_0100 << i) << i);
    @(negedge clk);
    #1;
    check("full_ready", 32'(bus.cmd_ready_o), 32'd0);
    check("full_count", 32'(bus.fifo_count_o), 32'(DEPTH));
    check("full_busy", 32'(bus.busy_o), 32'd1);
    check("full_res_valid", 32'(bus.res_valid_o), 32'd1);
    // Push offered in the same cycle the FIFO pops: must be refused
    @(negedge clk);
    bus.res_ready_i = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_data_i  = 32'hDEADBEEF;
    bus.cmd_tag_i   = 4'hF;
    #1 check("pop_cycle_ready", 32'(bus.cmd_ready_o), 32'd0);
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    check("pop_cycle_count", 32'(bus.fifo_count_o), 32'(DEPTH - 1));
    check("pop_cycle_ready_back", 32'(bus.cmd_ready_o), 32'd1);
    wait_drain();

    // Randomized traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) @(posedge clk);
          send_rand();
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          bus.res_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    bus.res_ready_i = 1'b1;
    wait_drain();

    // Reset with work in flight
    bus.res_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send_rand();
    @(negedge clk);
    #1 check("pre_rst_count", 32'(bus.fifo_count_o), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_data_q.delete();
    exp_tag_q.delete();
    check_idle("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("post_rst_no_result", 32'(bus.res_valid_o), 32'd0);
    end
    check("post_rst_busy", 32'(bus.busy_o), 32'd0);

    // Traffic still works after the flush
    send(32'h0F0F0F0F, 5'd8, 1'b0, 4'd10, 32'h0F0F0F00);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Buffered command front-end and result-capture stage for the 32-bit combinational barrel shifter (`barrel_shifter_multifunction`). It accepts shift commands over a valid/ready handshake and queues them in a small FIFO. It issues one command per cycle to the shifter and registers each shifter result with its tag onto a valid/ready result port. This turns the shifter into a fully pipelined, back-pressurable datapath unit.

## Interface
Parameters:
- DEPTH, 4, command FIFO depth; power of two, ≥2
- TAG_W, 4, width of the opaque command tag

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  FIFO can accept; equals count < DEPTH
- cmd_data_i  in  32  operand
- cmd_amt_i  in  5  shift amount 0–31
- cmd_right_i  in  1  1 = right shift, 0 = left shift
- cmd_tag_i  in  TAG_W  tag returned with the result
- sh_data_o  out  32  to shifter `data_i`
- sh_s_o  out  5  to shifter `s_i`
- sh_right_o  out  1  to shifter `right_i`
- sh_y_i  in  32  from shifter `o_y`
- res_valid_o  out  1  result register full
- res_ready_i  in  1  consumer accepts result
- res_data_o  out  32  registered shifter output
- res_tag_o  out  TAG_W  tag of that result
- fifo_count_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- busy_o  out  1  FIFO non-empty, issue register valid, or res_valid_o high

## Operation
- The block has three storage stages: FIFO, issue register (iss_v plus command fields), and result register (res_valid_o plus data and tag).
- Push: cmd_valid_i && cmd_ready_o at an edge writes the command at wr_ptr.
- Result advance: res_adv = iss_v && (!res_valid_o || res_ready_i). It loads res_data_o ← sh_y_i and res_tag_o ← issue tag, and sets res_valid_o.
- Result drain: res_ready_i && res_valid_o without res_adv clears res_valid_o.
- Issue advance: pop = fifo non-empty && (!iss_v || res_adv). It loads the FIFO head into the issue register and sets iss_v. Without pop, res_adv clears iss_v.
- Shifter drive: sh_data_o, sh_s_o and sh_right_o come straight from the issue register. They are held stable while stalled and keep their last value when iss_v = 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. There is no bypass: an empty FIFO still takes one edge.
- Full: cmd_ready_o = 0, and input is ignored regardless of a same-cycle pop. Ready reasserts the cycle after the pop.
- Pointers wrap modulo DEPTH. count is the authoritative full/empty indicator.
- The tag is opaque and never interpreted. Results leave in command order.

## Timing
- Reset forces count, pointers, iss_v and res_valid_o to 0. It also forces sh_*_o, res_data_o and res_tag_o to 0, and cmd_ready_o reads 1 from the first cycle after reset.
- Reset mid-operation flushes all queued and in-flight commands, and none of them produce results.
- Latency: a command accepted at edge E0 enters the issue register at E1 and appears on res_valid_o after E2. The earliest result is two cycles after acceptance.
- Throughput: one result per cycle while res_ready_i = 1 and commands arrive back-to-back.
- Stall: with res_ready_i = 0, the result register and issue register hold, and the FIFO fills. cmd_ready_o drops once count = DEPTH, after DEPTH + 2 accepted commands.
- The shifter path sh_*_o → sh_y_i is purely combinational within one cycle. There is no registered input on that path.

## Structure
- Package shift_seq_pkg holds:
  - DATA_W = 32 and AMT_W = 5
  - typedef shift_cmd_t {data, amt, right, tag}, with the tag sized via a parameterised struct or TAG_W default
- Sub-module shift_cmd_fifo is a synchronous FIFO (DEPTH, shift_cmd_t payload, push/pop/count/full/empty).
- The shifter is not instantiated inside this block; the top-level or bench wires it to the sh_* ports.

## Test plan
Bench connects sh_* to `barrel_shifter_multifunction`.
- Reset, then hold: all outputs 0, cmd_ready_o = 1, fifo_count_o = 0, busy_o = 0.
- Single command 0xA5A5A5A5, amt 4, right, tag 3: after 2 cycles res_data_o = 0x0A5A5A5A, res_tag_o = 3.
- Back-to-back with res_ready_i = 1:
  - left 4 on 0xA5A5A5A5 → 0x5A5A5A50
  - left 5 on 0x12345678 → 0x468ACF00
  - right 5 on 0x12345678 → 0x0091A2B3
  - results arrive on consecutive cycles, in order.
- Back-pressure, DEPTH = 4, res_ready_i = 0: 6 commands accepted, then cmd_ready_o = 0 and fifo_count_o = 4. Releasing res_ready_i drains all 6 in order, with no loss or duplication.
- Boundaries: amt 0 returns the data unchanged. Right 31 on 0xA5A5A5A5 → 0x00000001. A push during a full-cycle pop is refused.
- Reset asserted with 3 commands queued and one result pending: all valids clear next cycle, and no stale result appears afterwards.
